serial_clock_gen_ctrl: RTL and testbench

Parametrised serial-clock generator for the SoC's serial peripherals (SPI master, pixel-matrix configuration shifter). Produces SCK at a programmable half-period with selectable CPOL/CPHA and a bounded burst of N bits. Emits single-cycle edge, sample and shift strobes in the `clk` domain, so the attached shift register needs no clock-domain logic. Sits between the peripheral's register file and its data shifter.

---
 rtl/serial_clock_pkg.sv | 18 +
 rtl/sck_half_period_counter.sv | 26 ++
 rtl/serial_clock_gen_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_clock_gen_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_clock_pkg.sv
// Shared types for the serial clock generator: controller state and latched configuration.
package serial_clock_pkg;

    // Divider field width held in the configuration struct; raise it for wider dividers.
    localparam int unsigned SckDivWidth = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } sck_state_t;

    typedef struct packed {
        logic [SckDivWidth-1:0] divider;
        logic                   cpol;
        logic                   cpha;
    } sck_cfg_t;

endpackage

// File: rtl/sck_half_period_counter.sv
// Half-period counter: counts 0..target and flags the cycle where the count reaches target.
module sck_half_period_counter #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] target,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;

    assign tick = ~clear && (count_q == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_clock_gen_ctrl.sv
// Serial clock generator: programmable-rate SCK bursts with CPOL/CPHA and clk-domain strobes.
module serial_clock_gen_ctrl
    import serial_clock_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = SckDivWidth,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_divider,
    input  logic                 cfg_cpol,
    input  logic                 cfg_cpha,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_bits,
    input  logic                 abort,
    output logic                 sck,
    output logic                 rising_edge,
    output logic                 falling_edge,
    output logic                 sample,
    output logic                 shift,
    output logic                 busy,
    output logic                 done
);

    sck_state_t           state_q;
    sck_cfg_t             cfg_q;
    logic [CNT_WIDTH-1:0] num_bits_q;
    logic [CNT_WIDTH:0]   edge_cnt_q;
    logic [CNT_WIDTH:0]   total_edges;
    logic [DIV_WIDTH-1:0] div_target;
    logic                 tick;
    logic                 cnt_clear;
    logic                 all_edges_done;
    logic                 leading;
    logic                 final_edge;

    assign total_edges    = {num_bits_q, 1'b0};
    assign all_edges_done = (edge_cnt_q == total_edges);
    // edge_cnt_q counts edges already issued, so the edge about to be issued is edge_cnt_q+1.
    assign leading        = ~edge_cnt_q[0];
    assign final_edge     = ((edge_cnt_q + 1'b1) == total_edges);
    assign cnt_clear      = (state_q != StRun) || abort || all_edges_done;
    assign div_target     = DIV_WIDTH'(cfg_q.divider);

    sck_half_period_counter #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_half_period (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .target(div_target),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cfg_q        <= '0;
            num_bits_q   <= '0;
            edge_cnt_q   <= '0;
            sck          <= 1'b0;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            sample       <= 1'b0;
            shift        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            sample       <= 1'b0;
            shift        <= 1'b0;
            done         <= 1'b0;
            case (state_q)
                StIdle: begin
                    sck <= cfg_q.cpol;
                    if (cfg_valid) begin
                        cfg_q <= '{divider: SckDivWidth'(cfg_divider),
                                   cpol: cfg_cpol, cpha: cfg_cpha};
                    end else if (start) begin
                        if (num_bits == '0) begin
                            done <= 1'b1;
                        end else begin
                            num_bits_q <= num_bits;
                            edge_cnt_q <= '0;
                            busy       <= 1'b1;
                            state_q    <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                        sck        <= cfg_q.cpol;
                        edge_cnt_q <= '0;
                    end else if (all_edges_done) begin
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        edge_cnt_q <= '0;
                    end else if (tick) begin
                        sck          <= ~sck;
                        edge_cnt_q   <= edge_cnt_q + 1'b1;
                        rising_edge  <= ~sck;
                        falling_edge <= sck;
                        if (cfg_q.cpha) begin
                            shift  <= leading;
                            sample <= ~leading;
                        end else begin
                            sample <= leading;
                            shift  <= ~leading & ~final_edge;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_clock_gen_ctrl.sv
// Bench for serial_clock_gen_ctrl: timing-formula model checked every cycle plus literal checks.
module tb_serial_clock_gen_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_divider = '0;
    logic        cfg_cpol = 1'b0;
    logic        cfg_cpha = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_bits = '0;
    logic        abort = 1'b0;
    logic        sck, rising_edge, falling_edge, sample, shift, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_clock_gen_ctrl #(
        .DIV_WIDTH(8),
        .CNT_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_divider (cfg_divider),
        .cfg_cpol    (cfg_cpol),
        .cfg_cpha    (cfg_cpha),
        .start       (start),
        .num_bits    (num_bits),
        .abort       (abort),
        .sck         (sck),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .sample      (sample),
        .shift       (shift),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a burst started in cycle T with divider D and N bits has edge k at T+1+k*(D+1),
    // ends (busy low, done high) at T+2+2N*(D+1); sck = CPOL xor parity of edges seen so far.
    int   m_div = 0, m_cpol_l = 0, m_cpha_l = 0;
    bit   m_run = 0;
    int   m_t, m_n, m_d, m_pol, m_pha;
    int   per, r, k, eend;
    logic [6:0] exp_v = '0;  // {sck, rise, fall, sample, shift, busy, done}

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div = 0; m_cpol_l = 0; m_cpha_l = 0; m_run = 0;
            exp_v = '0;
        end else begin
            exp_v = '0;
            if (m_run) begin
                per  = m_d + 1;
                eend = m_t + 1 + 2 * m_n * per;
                if (abort) begin
                    m_run = 0;
                    exp_v[6] = m_pol[0];
                end else if (cyc == eend) begin
                    m_run = 0;
                    exp_v[6] = m_pol[0];
                    exp_v[0] = 1'b1;
                end else begin
                    exp_v[1] = 1'b1;
                    r = cyc - m_t;
                    k = r / per;
                    exp_v[6] = m_pol[0] ^ (k % 2 == 1);
                    if (r % per == 0) begin
                        exp_v[5] = exp_v[6];
                        exp_v[4] = ~exp_v[6];
                        if (m_pha != 0) begin
                            exp_v[2] = (k % 2 == 1);
                            exp_v[3] = (k % 2 == 0);
                        end else begin
                            exp_v[3] = (k % 2 == 1);
                            exp_v[2] = (k % 2 == 0) && (k != 2 * m_n);
                        end
                    end
                end
            end else begin
                exp_v[6] = m_cpol_l[0];
                if (cfg_valid) begin
                    m_div = cfg_divider; m_cpol_l = cfg_cpol; m_cpha_l = cfg_cpha;
                end else if (start) begin
                    if (num_bits == 0) begin
                        exp_v[0] = 1'b1;
                    end else begin
                        m_run = 1; m_t = cyc; m_n = num_bits; m_d = m_div;
                        m_pol = m_cpol_l; m_pha = m_cpha_l;
                        exp_v[1] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] act;
        act = {sck, rising_edge, falling_edge, sample, shift, busy, done};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %b expected %b (sck,rise,fall,smp,sft,busy,done)",
                     cyc, act, exp_v);
        end
    end

    // Event monitor feeding the hand-computed checks.
    int n_edge, n_rise, n_fall, n_smp, n_sft, n_smp_rise, n_sft_fall, n_done, n_busy;
    int first_edge, last_edge, min_gap, max_gap, done_cyc;

    task automatic clear_mon();
        n_edge = 0; n_rise = 0; n_fall = 0; n_smp = 0; n_sft = 0;
        n_smp_rise = 0; n_sft_fall = 0; n_done = 0; n_busy = 0;
        first_edge = -1; last_edge = -1; min_gap = 1000000; max_gap = -1; done_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rising_edge || falling_edge) begin
                if (first_edge < 0) first_edge = cyc;
                else begin
                    if (cyc - last_edge < min_gap) min_gap = cyc - last_edge;
                    if (cyc - last_edge > max_gap) max_gap = cyc - last_edge;
                end
                last_edge = cyc;
                n_edge++;
            end
            if (rising_edge) n_rise++;
            if (falling_edge) n_fall++;
            if (sample) n_smp++;
            if (shift) n_sft++;
            if (sample && rising_edge) n_smp_rise++;
            if (shift && falling_edge) n_sft_fall++;
            if (busy) n_busy++;
            if (done) begin n_done++; done_cyc = cyc; end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_cfg(input int d, input int pol, input int pha);
        step();
        cfg_valid = 1'b1; cfg_divider = 8'(d); cfg_cpol = pol[0]; cfg_cpha = pha[0];
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start(input int n, output int t);
        step();
        start = 1'b1; num_bits = 16'(n); t = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (n_done == 0 && i < budget) begin
            step();
            i++;
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL %s timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int t, t2, i;
        rst = 1'b1;
        clear_mon();
        steps(3);
        chk("reset_sck", sck, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        steps(2);

        // D=0, CPOL=0, CPHA=0, N=4
        do_cfg(0, 0, 0);
        clear_mon();
        do_start(4, t);
        wait_done("t1_done", 40);
        chk("t1_first_edge", first_edge, t + 2);
        chk("t1_last_edge", last_edge, t + 9);
        chk("t1_done_cycle", done_cyc, t + 10);
        chk("t1_samples_on_rise", n_smp_rise, 4);
        chk("t1_samples", n_smp, 4);
        chk("t1_shifts", n_sft, 3);
        chk("t1_edges", n_edge, 8);
        steps(2);

        // D=3, CPOL=1, CPHA=1, N=2; CPOL change must not strobe
        clear_mon();
        do_cfg(3, 1, 1);
        steps(3);
        chk("t2_idle_sck", sck, 1);
        chk("t2_idle_edges", n_edge, 0);
        clear_mon();
        do_start(2, t);
        wait_done("t2_done", 60);
        chk("t2_first_edge", first_edge, t + 5);
        chk("t2_min_gap", min_gap, 4);
        chk("t2_max_gap", max_gap, 4);
        chk("t2_shift_on_fall", n_sft_fall, 2);
        chk("t2_sample_on_rise", n_smp_rise, 2);
        chk("t2_done_cycle", done_cyc, t + 18);
        chk("t2_end_sck", sck, 1);
        steps(2);

        // Abort after edge 3 of N=8, D=1, then restart immediately
        do_cfg(1, 0, 0);
        clear_mon();
        do_start(8, t);
        i = 0;
        while (n_edge < 3 && i < 40) begin
            step();
            i++;
        end
        chk("t3_edge3_cycle", last_edge, t + 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_sck", sck, 0);
        chk("t3_abort_no_done", n_done, 0);
        start = 1'b1; num_bits = 16'd1; t2 = cyc;
        clear_mon();
        step();
        start = 1'b0;
        wait_done("t3_restart_done", 30);
        chk("t3_restart_done_cycle", done_cyc, t2 + 6);
        steps(2);

        // cfg_valid with start: config wins, no burst
        clear_mon();
        step();
        cfg_valid = 1'b1; cfg_divider = 8'd2; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        start = 1'b1; num_bits = 16'd3;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        steps(8);
        chk("t4_no_edges", n_edge, 0);
        chk("t4_no_busy", n_busy, 0);
        chk("t4_no_done", n_done, 0);
        // cfg_valid mid-burst is ignored: spacing stays D+1=3
        clear_mon();
        do_start(3, t);
        steps(2);
        cfg_valid = 1'b1; cfg_divider = 8'd0; cfg_cpol = 1'b1;
        step();
        cfg_valid = 1'b0;
        wait_done("t4_done", 60);
        chk("t4_min_gap", min_gap, 3);
        chk("t4_max_gap", max_gap, 3);
        chk("t4_done_cycle", done_cyc, t + 20);
        steps(3);
        chk("t4_cpol_kept", sck, 0);

        // N=0: done next cycle, no edges, never busy
        clear_mon();
        do_start(0, t);
        steps(4);
        chk("t5_done_cycle", done_cyc, t + 1);
        chk("t5_done_count", n_done, 1);
        chk("t5_edges", n_edge, 0);
        chk("t5_busy", n_busy, 0);

        // Reset mid-burst with CPOL=1 latched
        do_cfg(1, 1, 0);
        steps(3);
        chk("t6_idle_sck", sck, 1);
        clear_mon();
        do_start(8, t);
        steps(10);
        rst = 1'b1;
        #1;
        chk("t6_rst_sck", sck, 0);
        chk("t6_rst_busy", busy, 0);
        steps(2);
        rst = 1'b0;
        steps(5);
        chk("t6_post_sck", sck, 0);
        chk("t6_no_done", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
